// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: debounced buttons with sticky press events,
// and LED set/clear/toggle, behind the MMU request protocol.
module mmio_gpio #(
  parameter int   NUM_BTN    = 2,
  parameter int   NUM_LED    = 6,
  parameter int   DEBOUNCE   = 16,
  parameter logic BTN_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_LED-1:0] led,
  input  logic               read_enable,
  input  logic               write_enable,
  input  logic               mem_signed_read,
  input  logic [1:0]         mem_data_width,
  input  logic [3:0]         address,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               mem_ready,
  output logic               mem_error
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam logic [NUM_BTN-1:0] IDLE_PIN =
    {NUM_BTN{~BTN_ACTIVE}};

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state;

  logic [3:0]  addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  width_q;
  logic        signed_q;
  logic        we_q;
  logic        err_q;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] events;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] flip;
  logic [NUM_BTN-1:0] rise;
  logic [CW-1:0]      cnt [NUM_BTN];

  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] wsh;
  logic [31:0] rword;
  logic [31:0] rlane;
  logic [31:0] rdata;
  logic [31:0] clr;
  logic        misal;
  logic        err;

  always_comb begin
    pressed = sync2 ^ IDLE_PIN;
    for (int i = 0; i < NUM_BTN; i++) begin
      flip[i] = (pressed[i] != level[i])
              && (cnt[i] == CNT_LAST);
    end
    rise = flip & ~level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
      level <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      level <= level ^ flip;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (pressed[i] == level[i] || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    shamt = {addr_q[1:0], 3'b000};
    case (width_q)
      W_BYTE: begin
        lane_mask = 32'h0000_00FF << shamt;
        misal     = 1'b0;
      end
      W_HALF: begin
        lane_mask = 32'h0000_FFFF << shamt;
        misal     = addr_q[0];
      end
      W_WORD: begin
        lane_mask = 32'hFFFF_FFFF;
        misal     = |addr_q[1:0];
      end
      default: begin
        lane_mask = '0;
        misal     = 1'b1;
      end
    endcase
    wsh = wdata_q << shamt;
    err = misal | (we_q & ~addr_q[3]);

    rword = '0;
    case (addr_q[3:2])
      2'd0:    rword[NUM_BTN-1:0] = events;
      2'd1:    rword[NUM_BTN-1:0] = level;
      2'd2:    rword[NUM_LED-1:0] = led;
      default: rword = '0;
    endcase
    rlane = rword >> shamt;
    case (width_q)
      W_BYTE:
        rdata = {{24{signed_q & rlane[7]}},
                 rlane[7:0]};
      W_HALF:
        rdata = {{16{signed_q & rlane[15]}},
                 rlane[15:0]};
      default:
        rdata = rlane;
    endcase

    clr = '0;
    if (state == ACCESS && !we_q && !err
        && addr_q[3:2] == 2'd0) begin
      clr = lane_mask;
    end
  end

  // A press landing on the clearing cycle must survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      events <= '0;
    end else begin
      events <= (events & ~clr[NUM_BTN-1:0]) | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      led       <= '0;
      data_out  <= '0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      width_q   <= W_WORD;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (read_enable || write_enable) begin
            addr_q   <= address;
            wdata_q  <= data_in;
            width_q  <= mem_data_width;
            signed_q <= mem_signed_read;
            we_q     <= write_enable;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          err_q    <= err;
          data_out <= (err || we_q) ? '0 : rdata;
          if (we_q && !err) begin
            unique case (1'b1)
              addr_q[3:2] == 2'd2:
                led <= (led & ~lane_mask[NUM_LED-1:0])
                     | (wsh[NUM_LED-1:0]
                        & lane_mask[NUM_LED-1:0]);
              addr_q[3:2] == 2'd3:
                led <= led ^ (wsh[NUM_LED-1:0]
                              & lane_mask[NUM_LED-1:0]);
              default: led <= led;
            endcase
          end
          state <= DONE;
        end
        DONE: begin
          mem_ready <= 1'b1;
          mem_error <= err_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio with an expected-response queue.
// Buttons are active-low; idle pin level is 1.
module tb_mmio_gpio;

  localparam int NB  = 2;
  localparam int NL  = 6;
  localparam int DEB = 16;
  localparam logic [1:0] WB = 2'd0;
  localparam logic [1:0] WH = 2'd1;
  localparam logic [1:0] WW = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn;
  logic [NL-1:0] led;
  logic          read_enable;
  logic          write_enable;
  logic          mem_signed_read;
  logic [1:0]    mem_data_width;
  logic [3:0]    address;
  logic [31:0]   data_in;
  logic [31:0]   data_out;
  logic          mem_ready;
  logic          mem_error;

  int compared = 0;
  int failed   = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  mmio_gpio #(
    .NUM_BTN(NB),
    .NUM_LED(NL),
    .DEBOUNCE(DEB),
    .BTN_ACTIVE(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .led(led),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .mem_signed_read(mem_signed_read),
    .mem_data_width(mem_data_width),
    .address(address),
    .data_in(data_in),
    .data_out(data_out),
    .mem_ready(mem_ready),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      failed++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic acc(input string tag,
                     input logic we,
                     input logic [1:0] w,
                     input logic sg,
                     input logic [3:0] a,
                     input logic [31:0] d,
                     input logic [31:0] ed,
                     input logic ee);
    exp_t e;
    int   cyc;
    logic seen;
    e.tag  = tag;
    e.data = ed;
    e.err  = ee;
    sb.push_back(e);
    write_enable    = we;
    read_enable     = ~we;
    mem_data_width  = w;
    mem_signed_read = sg;
    address         = a;
    data_in         = d;
    @(negedge clk);
    read_enable  = 1'b0;
    write_enable = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      seen = mem_ready;
    end
    e = sb.pop_front();
    chk({e.tag, "_ready"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({e.tag, "_lat"}, cyc, 32'd2);
      chk({e.tag, "_data"}, data_out, e.data);
      chk({e.tag, "_err"}, 32'(mem_error),
          32'(e.err));
    end
  endtask

  initial begin
    int   n;
    logic saw;
    reset           = 1'b1;
    btn             = 2'b11;
    read_enable     = 1'b0;
    write_enable    = 1'b0;
    mem_signed_read = 1'b0;
    mem_data_width  = WW;
    address         = 4'h0;
    data_in         = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_err", 32'(mem_error), 32'h0);
    chk("rst_dout", data_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    acc("rd_led0", 1'b0, WW, 1'b0, 4'h8, 0, 0, 0);
    chk("led0", 32'(led), 32'h0);

    btn = 2'b10;
    repeat (DEB + 3) @(negedge clk);
    acc("ev1", 1'b0, WW, 1'b0, 4'h0, 0, 1, 0);
    acc("ev1_clr", 1'b0, WW, 1'b0, 4'h0, 0, 0, 0);
    acc("lvl1", 1'b0, WW, 1'b0, 4'h4, 0, 1, 0);
    btn = 2'b11;
    repeat (DEB + 8) @(negedge clk);
    acc("lvl_rel", 1'b0, WW, 1'b0, 4'h4, 0, 0, 0);
    acc("ev_rel", 1'b0, WW, 1'b0, 4'h0, 0, 0, 0);

    btn = 2'b01;
    repeat (10) @(negedge clk);
    btn = 2'b11;
    repeat (DEB + 8) @(negedge clk);
    acc("gl_lvl", 1'b0, WW, 1'b0, 4'h4, 0, 0, 0);
    acc("gl_ev", 1'b0, WW, 1'b0, 4'h0, 0, 0, 0);

    acc("wr3f", 1'b1, WW, 1'b0, 4'h8,
        32'h3F, 0, 0);
    chk("led_3f", 32'(led), 32'h3F);
    acc("tgl05", 1'b1, WB, 1'b0, 4'hC,
        32'h05, 0, 0);
    chk("led_3a", 32'(led), 32'h3A);
    acc("rd_sb", 1'b0, WB, 1'b1, 4'h8,
        0, 32'h3A, 0);
    acc("rd_tgl", 1'b0, WW, 1'b0, 4'hC, 0, 0, 0);
    acc("wr_ca", 1'b1, WW, 1'b0, 4'h8,
        32'h69BABACA, 0, 0);
    chk("led_0a", 32'(led), 32'h0A);
    acc("tgl_all", 1'b1, WW, 1'b0, 4'hC,
        32'hFFFFFFFF, 0, 0);
    chk("led_35", 32'(led), 32'h35);
    acc("tgl_ln1", 1'b1, WB, 1'b0, 4'hD,
        32'hFF, 0, 0);
    chk("led_ln1", 32'(led), 32'h35);
    acc("wr_mis", 1'b1, WW, 1'b0, 4'hA,
        32'h0, 0, 1);
    acc("wr_lvl", 1'b1, WW, 1'b0, 4'h4,
        32'h0, 0, 1);
    chk("led_err", 32'(led), 32'h35);

    btn = 2'b10;
    repeat (DEB + 6) @(negedge clk);
    btn = 2'b11;
    acc("rd_mis", 1'b0, WH, 1'b0, 4'h1, 0, 0, 1);
    acc("ev_kept", 1'b0, WW, 1'b0, 4'h0, 0, 1, 0);
    acc("ev_gone", 1'b0, WW, 1'b0, 4'h0, 0, 0, 0);
    repeat (DEB + 8) @(negedge clk);

    btn = 2'b01;
    repeat (DEB) @(negedge clk);
    acc("race_rd", 1'b0, WB, 1'b0, 4'h0, 0, 0, 0);
    acc("race_set", 1'b0, WB, 1'b0, 4'h0, 0, 2, 0);
    acc("race_clr", 1'b0, WB, 1'b0, 4'h0, 0, 0, 0);
    btn = 2'b11;

    write_enable   = 1'b1;
    mem_data_width = WW;
    address        = 4'h8;
    data_in        = 32'h15;
    @(negedge clk);
    write_enable = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    saw   = 1'b0;
    for (n = 0; n < 6; n++) begin
      @(negedge clk);
      saw = saw | mem_ready;
    end
    chk("abort_rdy", 32'(saw), 32'h0);
    chk("abort_led", 32'(led), 32'h0);
    acc("post_rst", 1'b0, WW, 1'b0, 4'h8, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

endmodule
